// File: rtl/tp_ram_bist_pkg.sv
// tp_ram_bist_pkg
// Shared RTAP BIST command encodings (chain-wide defines), the BIST FSM state
// type and the payload-length helper used by the two-port RAM wrapper.
// No ports.

`ifndef BIST_OP_WIDTH
`define BIST_OP_WIDTH            3
`define SRAM_WRAPPER_BUS_WIDTH   4
`define BIST_OP_NOP              3'd0
`define BIST_OP_SHIFT_ID         3'd1
`define BIST_OP_SHIFT_BSEL       3'd2
`define BIST_OP_SHIFT_ADDRESS    3'd3
`define BIST_OP_SHIFT_DATA       3'd4
`define BIST_OP_READ             3'd5
`endif

package tp_ram_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ID         = 4'd1,
    ST_BSEL       = 4'd2,
    ST_ADDR       = 4'd3,
    ST_RW_CHECK   = 4'd4,
    ST_READ_SRAM  = 4'd5,
    ST_READ_WAIT  = 4'd6,
    ST_SEND_DATA  = 4'd7,
    ST_RECV_DATA  = 4'd8,
    ST_WRITE_SRAM = 4'd9
  } bist_state_e;

  // Number of 4-bit nibbles needed to carry a word of the given width.
  function automatic int nib_count(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/tp_ram_asic.sv
// tp_ram_asic
// Simulation view of the hardened 1R1W macro; the library cell of the same
// name replaces this view at implementation. Same port contract as
// tp_ram_model.

module tp_ram_asic #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask
);

  tp_ram_model #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_view (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_mask (wr_mask)
  );

endmodule

// File: rtl/tp_ram_bist_ctrl.sv
// tp_ram_bist_ctrl
// RTAP BIST slave: decodes the nibble-serial command stream, selects this
// SRAM by chain ID, and performs one full-word read or write per transaction.
// Ports: clk, rst_n; sr_id; cmd/din (RTAP in), dout (RTAP out nibble);
// busy (macro owned); mem_rd_en/mem_wr_en/mem_addr/mem_wdata/mem_rdata.

module tp_ram_bist_ctrl
  import tp_ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         sr_id,
  input  logic [`BIST_OP_WIDTH-1:0]          cmd,
  input  logic [`SRAM_WRAPPER_BUS_WIDTH-1:0] din,
  output logic [`SRAM_WRAPPER_BUS_WIDTH-1:0] dout,
  output logic                               busy,
  output logic                               mem_rd_en,
  output logic                               mem_wr_en,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
);

  localparam int         NIB      = nib_count(DATA_WIDTH);
  localparam int         SRW      = 4 * NIB;
  localparam logic [7:0] NIB_LAST = 8'(NIB - 1);

  bist_state_e     state_r;
  logic [3:0]      id_hi_r;
  logic [7:0]      bsel_r;
  logic [15:0]     addr_r;
  logic [7:0]      cnt_r;
  logic [SRW-1:0]  sr_r;
  logic            busy_r;
  logic [3:0]      dout_r;

  logic [SRW-1:0]  sr_shl_s;
  logic [SRW-1:0]  rd_ext_s;
  logic [SRW-1:0]  nib_ext_s;
  logic            unused_s;

  // Shift and zero-extension helpers; width-safe even for a single-nibble word.
  always_comb begin
    sr_shl_s  = sr_r << 3'd4;
    rd_ext_s  = SRW'(mem_rdata);
    nib_ext_s = SRW'(din);
  end

  // BIST FSM with registered busy flag and output nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      id_hi_r <= 4'h0;
      bsel_r  <= 8'h00;
      addr_r  <= 16'h0000;
      cnt_r   <= 8'h00;
      sr_r    <= {SRW{1'b0}};
      busy_r  <= 1'b0;
      dout_r  <= 4'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd == `BIST_OP_SHIFT_ID) begin
            id_hi_r <= din;
            state_r <= ST_ID;
          end
        end
        ST_ID: begin
          if (cmd == `BIST_OP_SHIFT_ID) begin
            cnt_r   <= 8'h00;
            state_r <= ({id_hi_r, din} == sr_id) ? ST_BSEL : ST_IDLE;
          end else if (cmd != `BIST_OP_NOP) begin
            state_r <= ST_IDLE;
          end
        end
        ST_BSEL: begin
          if (cmd == `BIST_OP_SHIFT_BSEL) begin
            bsel_r <= {bsel_r[3:0], din};
            if (cnt_r == 8'h01) begin
              cnt_r   <= 8'h00;
              state_r <= ST_ADDR;
            end else begin
              cnt_r <= cnt_r + 8'h01;
            end
          end else if (cmd != `BIST_OP_NOP) begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (cmd == `BIST_OP_SHIFT_ADDRESS) begin
            addr_r <= {addr_r[11:0], din};
            if (cnt_r == 8'h03) begin
              cnt_r   <= 8'h00;
              busy_r  <= 1'b1;
              state_r <= ST_RW_CHECK;
            end else begin
              cnt_r <= cnt_r + 8'h01;
            end
          end else if (cmd != `BIST_OP_NOP) begin
            state_r <= ST_IDLE;
          end
        end
        ST_RW_CHECK: begin
          if (cmd == `BIST_OP_READ) begin
            state_r <= ST_READ_SRAM;
          end else if (cmd == `BIST_OP_SHIFT_DATA) begin
            sr_r    <= nib_ext_s;
            cnt_r   <= 8'h01;
            state_r <= (NIB == 1) ? ST_WRITE_SRAM : ST_RECV_DATA;
          end else if (cmd != `BIST_OP_NOP) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_READ_SRAM: begin
          state_r <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          // Macro output is valid now; first nibble goes straight to the pin register.
          sr_r    <= rd_ext_s;
          dout_r  <= rd_ext_s[SRW-1 -: 4];
          cnt_r   <= 8'h00;
          state_r <= ST_SEND_DATA;
        end
        ST_SEND_DATA: begin
          if (cmd == `BIST_OP_SHIFT_DATA) begin
            sr_r  <= sr_shl_s;
            cnt_r <= cnt_r + 8'h01;
            if (cnt_r == NIB_LAST) begin
              dout_r  <= 4'h0;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              dout_r <= sr_shl_s[SRW-1 -: 4];
            end
          end else if (cmd != `BIST_OP_NOP) begin
            dout_r  <= 4'h0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RECV_DATA: begin
          if (cmd == `BIST_OP_SHIFT_DATA) begin
            sr_r  <= sr_shl_s | nib_ext_s;
            cnt_r <= cnt_r + 8'h01;
            if (cnt_r == NIB_LAST) begin
              state_r <= ST_WRITE_SRAM;
            end
          end else if (cmd != `BIST_OP_NOP) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE_SRAM: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          dout_r  <= 4'h0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout      = dout_r;
  assign busy      = busy_r;
  assign mem_rd_en = (state_r == ST_READ_SRAM);
  assign mem_wr_en = (state_r == ST_WRITE_SRAM);
  assign mem_addr  = addr_r[ADDR_WIDTH-1:0];
  assign mem_wdata = sr_r[DATA_WIDTH-1:0];

  // Bank-select nibbles and high address bits are accepted but have no function here.
  assign unused_s = ^{bsel_r, addr_r, sr_r};

endmodule

// File: rtl/tp_ram_model.sv
// tp_ram_model
// Behavioural 1R1W RAM: registered read (1-cycle latency), bit-masked write.
// A same-address read and write in one cycle returns the old word.
// Ports: clk; rd_en/rd_addr/rd_data; wr_en/wr_addr/wr_data/wr_mask.

module tp_ram_model #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Storage array and read register; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= (mem_r[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/tp_ram_bist.sv
// tp_ram_bist
// Two-port (1R + 1W) RAM wrapper with RTAP BIST access, optional zero-fill
// after reset and optional same-address read-during-write bypass.
// Ports: clk, rst_n, SR_ID; user read (rd_en, rd_addr, rd_data);
// user write (wr_en, wr_addr, wr_data, wr_mask); init_done; bist_busy;
// RTAP: rtap_srams_bist_command, rtap_srams_bist_data, srams_rtap_data.
// Macro port priority: init, then BIST, then user.

module tp_ram_bist
  import tp_ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH              = 6,
  parameter int DATA_WIDTH              = 64,
  parameter int INSTANTIATE_ASIC_MEMORY = 1,
  parameter int INIT_MEMORY_ON_RESET    = 0,
  parameter int BYPASS_RDW              = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         SR_ID,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]              rd_data,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [DATA_WIDTH-1:0]              wr_mask,
  output logic                               init_done,
  output logic                               bist_busy,
  output logic [`SRAM_WRAPPER_BUS_WIDTH-1:0] srams_rtap_data,
  input  logic [`BIST_OP_WIDTH-1:0]          rtap_srams_bist_command,
  input  logic [`SRAM_WRAPPER_BUS_WIDTH-1:0] rtap_srams_bist_data
);

  localparam logic INIT_EN = (INIT_MEMORY_ON_RESET != 0);
  localparam logic BYP_EN  = (BYPASS_RDW != 0);

  logic                  init_done_r;
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic                  byp_sel_r;
  logic [DATA_WIDTH-1:0] byp_data_r;
  logic [DATA_WIDTH-1:0] byp_mask_r;

  logic [`BIST_OP_WIDTH-1:0] ctrl_cmd_s;
  logic                  bist_busy_s;
  logic                  bist_rd_s;
  logic                  bist_wr_s;
  logic [ADDR_WIDTH-1:0] bist_addr_s;
  logic [DATA_WIDTH-1:0] bist_wdata_s;
  logic                  user_ok_s;

  logic                  mem_rd_en_s;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic                  mem_wr_en_s;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] mem_wmask_s;

  // Zero-fill sequencer: one write per cycle, done flag rises after the last index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_r <= ~INIT_EN;
      init_cnt_r  <= {ADDR_WIDTH{1'b0}};
    end else if (!init_done_r) begin
      init_cnt_r <= init_cnt_r + ADDR_WIDTH'(1'b1);
      if (init_cnt_r == {ADDR_WIDTH{1'b1}}) begin
        init_done_r <= 1'b1;
      end
    end
  end

  // BIST commands are masked during zero-fill so no transaction can collide with it.
  assign ctrl_cmd_s = init_done_r ? rtap_srams_bist_command : `BIST_OP_NOP;

  tp_ram_bist_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .sr_id     (SR_ID),
    .cmd       (ctrl_cmd_s),
    .din       (rtap_srams_bist_data),
    .dout      (srams_rtap_data),
    .busy      (bist_busy_s),
    .mem_rd_en (bist_rd_s),
    .mem_wr_en (bist_wr_s),
    .mem_addr  (bist_addr_s),
    .mem_wdata (bist_wdata_s),
    .mem_rdata (mem_rdata_s)
  );

  // Macro port arbitration: init over BIST over user.
  always_comb begin
    user_ok_s     = init_done_r & ~bist_busy_s;
    mem_wr_en_s   = 1'b0;
    mem_wr_addr_s = wr_addr;
    mem_wdata_s   = wr_data;
    mem_wmask_s   = wr_mask;
    if (!init_done_r) begin
      mem_wr_en_s   = 1'b1;
      mem_wr_addr_s = init_cnt_r;
      mem_wdata_s   = {DATA_WIDTH{1'b0}};
      mem_wmask_s   = {DATA_WIDTH{1'b1}};
    end else if (bist_wr_s) begin
      mem_wr_en_s   = 1'b1;
      mem_wr_addr_s = bist_addr_s;
      mem_wdata_s   = bist_wdata_s;
      mem_wmask_s   = {DATA_WIDTH{1'b1}};
    end else begin
      mem_wr_en_s   = user_ok_s & wr_en;
    end
    if (bist_rd_s) begin
      mem_rd_en_s   = 1'b1;
      mem_rd_addr_s = bist_addr_s;
    end else begin
      mem_rd_en_s   = user_ok_s & rd_en;
      mem_rd_addr_s = rd_addr;
    end
  end

  // Capture the write for a same-address user read so masked bits return new data next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_sel_r  <= 1'b0;
      byp_data_r <= {DATA_WIDTH{1'b0}};
      byp_mask_r <= {DATA_WIDTH{1'b0}};
    end else begin
      byp_sel_r  <= BYP_EN & user_ok_s & rd_en & wr_en & (rd_addr == wr_addr);
      byp_data_r <= wr_data & wr_mask;
      byp_mask_r <= wr_mask;
    end
  end

  assign rd_data   = byp_sel_r ? (byp_data_r | (mem_rdata_s & ~byp_mask_r)) : mem_rdata_s;
  assign init_done = init_done_r;
  assign bist_busy = bist_busy_s;

  if (INSTANTIATE_ASIC_MEMORY != 0) begin : g_asic
    tp_ram_asic #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
      .clk     (clk),
      .rd_en   (mem_rd_en_s),
      .rd_addr (mem_rd_addr_s),
      .rd_data (mem_rdata_s),
      .wr_en   (mem_wr_en_s),
      .wr_addr (mem_wr_addr_s),
      .wr_data (mem_wdata_s),
      .wr_mask (mem_wmask_s)
    );
  end else begin : g_model
    tp_ram_model #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
      .clk     (clk),
      .rd_en   (mem_rd_en_s),
      .rd_addr (mem_rd_addr_s),
      .rd_data (mem_rdata_s),
      .wr_en   (mem_wr_en_s),
      .wr_addr (mem_wr_addr_s),
      .wr_data (mem_wdata_s),
      .wr_mask (mem_wmask_s)
    );
  end

endmodule

// File: tb/tb_tp_ram_bist.sv
// tb_tp_ram_bist
// Directed bench: a 64-bit, 16-word instance with zero-fill (chain ID 0x3A)
// and a 10-bit instance without zero-fill (chain ID 0x15) share the RTAP bus.

`ifndef BIST_OP_WIDTH
`define BIST_OP_WIDTH            3
`define SRAM_WRAPPER_BUS_WIDTH   4
`define BIST_OP_NOP              3'd0
`define BIST_OP_SHIFT_ID         3'd1
`define BIST_OP_SHIFT_BSEL       3'd2
`define BIST_OP_SHIFT_ADDRESS    3'd3
`define BIST_OP_SHIFT_DATA       3'd4
`define BIST_OP_READ             3'd5
`endif

module tb_tp_ram_bist;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cmd;
  logic [3:0]  bdata;

  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] wr_mask;
  logic        init_done;
  logic        bist_busy;
  logic [3:0]  tdo;

  logic        rd_en10;
  logic [5:0]  rd_addr10;
  logic [9:0]  rd_data10;
  logic        wr_en10;
  logic [5:0]  wr_addr10;
  logic [9:0]  wr_data10;
  logic [9:0]  wr_mask10;
  logic        init_done10;
  logic        busy10;
  logic [3:0]  tdo10;

  int checks;
  int failures;

  tp_ram_bist #(
    .ADDR_WIDTH(4), .DATA_WIDTH(64), .INSTANTIATE_ASIC_MEMORY(1),
    .INIT_MEMORY_ON_RESET(1), .BYPASS_RDW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .SR_ID(8'h3A),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .init_done(init_done), .bist_busy(bist_busy), .srams_rtap_data(tdo),
    .rtap_srams_bist_command(cmd), .rtap_srams_bist_data(bdata)
  );

  tp_ram_bist #(
    .ADDR_WIDTH(6), .DATA_WIDTH(10), .INSTANTIATE_ASIC_MEMORY(0),
    .INIT_MEMORY_ON_RESET(0), .BYPASS_RDW(1)
  ) dut10 (
    .clk(clk), .rst_n(rst_n), .SR_ID(8'h15),
    .rd_en(rd_en10), .rd_addr(rd_addr10), .rd_data(rd_data10),
    .wr_en(wr_en10), .wr_addr(wr_addr10), .wr_data(wr_data10), .wr_mask(wr_mask10),
    .init_done(init_done10), .bist_busy(busy10), .srams_rtap_data(tdo10),
    .rtap_srams_bist_command(cmd), .rtap_srams_bist_data(bdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [3:0] n);
    cmd   = c;
    bdata = n;
    cyc();
    cmd   = `BIST_OP_NOP;
    bdata = 4'h0;
  endtask

  task automatic hdr(input logic [7:0] id, input logic [15:0] a);
    send(`BIST_OP_SHIFT_ID, id[7:4]);
    send(`BIST_OP_SHIFT_ID, id[3:0]);
    send(`BIST_OP_SHIFT_BSEL, 4'h0);
    send(`BIST_OP_SHIFT_BSEL, 4'h0);
    send(`BIST_OP_SHIFT_ADDRESS, a[15:12]);
    send(`BIST_OP_SHIFT_ADDRESS, a[11:8]);
    send(`BIST_OP_SHIFT_ADDRESS, a[7:4]);
    send(`BIST_OP_SHIFT_ADDRESS, a[3:0]);
  endtask

  task automatic user_read(input logic [3:0] a, output logic [63:0] v);
    rd_en   = 1'b1;
    rd_addr = a;
    cyc();
    rd_en   = 1'b0;
    v       = rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %0b expected 0", init_done); end
    checks++;
    if (bist_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bist_busy); end
    checks++;
    if (tdo !== 4'h0) begin failures++; $display("FAIL reset_tdo: got %0h expected 0", tdo); end
    checks++;
    if (init_done10 !== 1'b1) begin failures++; $display("FAIL reset_init_done10: got %0b expected 1", init_done10); end
  endtask

  task automatic test_init();
    logic [63:0] v;
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'h2;
    wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (15) cyc();
    checks++;
    if (init_done !== 1'b0) begin failures++; $display("FAIL init_early: got %0b expected 0 after 15 cycles", init_done); end
    cyc();
    wr_en = 1'b0;
    checks++;
    if (init_done !== 1'b1) begin failures++; $display("FAIL init_done: got %0b expected 1 after 16 cycles", init_done); end
    for (int a = 0; a < 16; a++) begin
      user_read(4'(a), v);
      checks++;
      if (v !== 64'h0) begin failures++; $display("FAIL init_zero[%0d]: got %h expected 0", a, v); end
    end
  endtask

  task automatic test_user_rw();
    logic [63:0] v;
    wr_en = 1'b1; wr_addr = 4'h5; wr_data = 64'hDEADBEEF_01234567; wr_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    wr_en = 1'b0;
    user_read(4'h5, v);
    checks++;
    if (v !== 64'hDEADBEEF_01234567) begin failures++; $display("FAIL user_rw5: got %h expected deadbeef01234567", v); end
    wr_en = 1'b1; wr_addr = 4'h9; wr_data = 64'hA5A5A5A5_A5A5A5A5; wr_mask = 64'hFFFF0000_FFFF0000;
    cyc();
    wr_en = 1'b0;
    user_read(4'h9, v);
    checks++;
    if (v !== 64'hA5A50000_A5A50000) begin failures++; $display("FAIL user_mask9: got %h expected a5a50000a5a50000", v); end
  endtask

  task automatic test_rdw_bypass();
    logic [63:0] v;
    wr_en = 1'b1; wr_addr = 4'h5; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; wr_mask = 64'h0000_0000_FFFF_FFFF;
    rd_en = 1'b1; rd_addr = 4'h5;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (rd_data !== 64'hDEADBEEF_FFFFFFFF) begin failures++; $display("FAIL rdw_bypass: got %h expected deadbeefffffffff", rd_data); end
    user_read(4'h5, v);
    checks++;
    if (v !== 64'hDEADBEEF_FFFFFFFF) begin failures++; $display("FAIL rdw_commit: got %h expected deadbeefffffffff", v); end
  endtask

  task automatic test_bist_write_read();
    logic [63:0] v;
    hdr(8'h3A, 16'h0007);
    checks++;
    if (bist_busy !== 1'b1) begin failures++; $display("FAIL bist_busy_rwcheck: got %0b expected 1", bist_busy); end
    for (int k = 0; k < 16; k++) begin
      send(`BIST_OP_SHIFT_DATA, 4'(k));
      checks++;
      if (bist_busy !== 1'b1) begin failures++; $display("FAIL bist_busy_recv[%0d]: got %0b expected 1", k, bist_busy); end
    end
    cyc();
    checks++;
    if (bist_busy !== 1'b0) begin failures++; $display("FAIL bist_busy_after_wr: got %0b expected 0", bist_busy); end
    checks++;
    if (busy10 !== 1'b0) begin failures++; $display("FAIL other_id_busy: got %0b expected 0", busy10); end
    user_read(4'h7, v);
    checks++;
    if (v !== 64'h01234567_89ABCDEF) begin failures++; $display("FAIL bist_wr_mem: got %h expected 0123456789abcdef", v); end
    // Upper address bits beyond the 4-bit array are ignored.
    hdr(8'h3A, 16'hFFF7);
    send(`BIST_OP_READ, 4'h0);
    cyc();
    checks++;
    if (tdo !== 4'h0) begin failures++; $display("FAIL bist_rd_wait_tdo: got %0h expected 0", tdo); end
    cyc();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (tdo !== 4'(k) || bist_busy !== 1'b1) begin
        failures++;
        $display("FAIL bist_rd_nib[%0d]: got tdo=%0h busy=%0b expected tdo=%0h busy=1", k, tdo, bist_busy, k);
      end
      send(`BIST_OP_SHIFT_DATA, 4'h0);
    end
    checks++;
    if (tdo !== 4'h0 || bist_busy !== 1'b0) begin
      failures++; $display("FAIL bist_rd_end: got tdo=%0h busy=%0b expected tdo=0 busy=0", tdo, bist_busy);
    end
  endtask

  task automatic test_bist_abort();
    logic [63:0] v;
    logic        busy_seen;
    busy_seen = 1'b0;
    hdr(8'h3B, 16'h0005);
    busy_seen = busy_seen | bist_busy;
    for (int k = 0; k < 16; k++) begin
      send(`BIST_OP_SHIFT_DATA, 4'h3);
      busy_seen = busy_seen | bist_busy;
    end
    cyc();
    checks++;
    if (busy_seen !== 1'b0) begin failures++; $display("FAIL id_mismatch_busy: got %0b expected 0", busy_seen); end
    user_read(4'h5, v);
    checks++;
    if (v !== 64'hDEADBEEF_FFFFFFFF) begin failures++; $display("FAIL id_mismatch_mem: got %h expected deadbeefffffffff", v); end
    busy_seen = 1'b0;
    send(`BIST_OP_SHIFT_ID, 4'h3);
    send(`BIST_OP_SHIFT_ID, 4'hA);
    send(`BIST_OP_READ, 4'h0);
    for (int k = 0; k < 4; k++) begin
      send(`BIST_OP_SHIFT_ADDRESS, 4'h0);
      busy_seen = busy_seen | bist_busy;
    end
    for (int k = 0; k < 16; k++) begin
      send(`BIST_OP_SHIFT_DATA, 4'h3);
      busy_seen = busy_seen | bist_busy;
    end
    cyc();
    checks++;
    if (busy_seen !== 1'b0) begin failures++; $display("FAIL bsel_abort_busy: got %0b expected 0", busy_seen); end
    user_read(4'h0, v);
    checks++;
    if (v !== 64'h0) begin failures++; $display("FAIL bsel_abort_mem: got %h expected 0", v); end
  endtask

  task automatic bist10_readback(input string tag);
    hdr(8'h15, 16'h0003);
    send(`BIST_OP_READ, 4'h0);
    cyc();
    cyc();
    checks++;
    if (tdo10 !== 4'h2) begin failures++; $display("FAIL %s_nib0: got %0h expected 2", tag, tdo10); end
    send(`BIST_OP_SHIFT_DATA, 4'h0);
    checks++;
    if (tdo10 !== 4'hA) begin failures++; $display("FAIL %s_nib1: got %0h expected a", tag, tdo10); end
    send(`BIST_OP_SHIFT_DATA, 4'h0);
    checks++;
    if (tdo10 !== 4'h5) begin failures++; $display("FAIL %s_nib2: got %0h expected 5", tag, tdo10); end
    send(`BIST_OP_SHIFT_DATA, 4'h0);
    checks++;
    if (tdo10 !== 4'h0 || busy10 !== 1'b0) begin
      failures++; $display("FAIL %s_end: got tdo=%0h busy=%0b expected tdo=0 busy=0", tag, tdo10, busy10);
    end
  endtask

  task automatic test_dw10();
    hdr(8'h15, 16'h0003);
    send(`BIST_OP_SHIFT_DATA, 4'h2);
    send(`BIST_OP_SHIFT_DATA, 4'hA);
    send(`BIST_OP_SHIFT_DATA, 4'h5);
    checks++;
    if (busy10 !== 1'b1) begin failures++; $display("FAIL dw10_busy_wr: got %0b expected 1", busy10); end
    cyc();
    checks++;
    if (busy10 !== 1'b0) begin failures++; $display("FAIL dw10_busy_done: got %0b expected 0", busy10); end
    bist10_readback("dw10_rd");
  endtask

  task automatic test_reset_mid_recv();
    hdr(8'h15, 16'h0003);
    send(`BIST_OP_SHIFT_DATA, 4'h1);
    send(`BIST_OP_SHIFT_DATA, 4'hC);
    checks++;
    if (busy10 !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %0b expected 1", busy10); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy10 !== 1'b0 || tdo10 !== 4'h0) begin
      failures++; $display("FAIL midrst_async: got busy=%0b tdo=%0h expected busy=0 tdo=0", busy10, tdo10);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    repeat (16) cyc();
    checks++;
    if (init_done !== 1'b1) begin failures++; $display("FAIL midrst_reinit: got %0b expected 1", init_done); end
    send(`BIST_OP_SHIFT_DATA, 4'h3);
    checks++;
    if (busy10 !== 1'b0) begin failures++; $display("FAIL midrst_idle: got %0b expected 0", busy10); end
    bist10_readback("midrst_rd");
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    cmd       = `BIST_OP_NOP;
    bdata     = 4'h0;
    rd_en     = 1'b0;
    rd_addr   = 4'h0;
    wr_en     = 1'b0;
    wr_addr   = 4'h0;
    wr_data   = 64'h0;
    wr_mask   = 64'h0;
    rd_en10   = 1'b0;
    rd_addr10 = 6'h00;
    wr_en10   = 1'b0;
    wr_addr10 = 6'h00;
    wr_data10 = 10'h000;
    wr_mask10 = 10'h000;
    test_reset();
    test_init();
    test_user_rw();
    test_rdw_bypass();
    test_bist_write_read();
    test_bist_abort();
    test_dw10();
    test_reset_mid_recv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tp_ram_bist.md
# tp_ram_bist

Two-port (1 read + 1 write) RAM wrapper with JTAG/RTAP BIST debug access and optional zero-initialisation on reset. It generalises our single-port wrapper in three ways:
- separate read and write ports;
- BIST serial payload length scaled to DATA_WIDTH rather than fixed frame sizes;
- configurable read-during-write bypass.

It sits between cache/queue logic and the physical macro (ASIC) or behavioural model (sim/FPGA), on the same RTAP SRAM chain as the existing wrappers.

## Interface
- ADDR_WIDTH, 6, address bits (≤16).
- DATA_WIDTH, 64, word width (≤512).
- INSTANTIATE_ASIC_MEMORY, 1, 1: ASIC macro, 0: behavioural model.
- INIT_MEMORY_ON_RESET, 0, 1: write zero to every address after reset.
- BYPASS_RDW, 1, 1: same-address read-during-write returns the new data for masked bits.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- SR_ID  in  8  this SRAM's chain ID.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data, 1-cycle latency.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_mask  in  DATA_WIDTH  bit-write enable, 1 = write.
- init_done  out  1  initialisation finished.
- bist_busy  out  1  BIST owns the macro; user requests are dropped.
- srams_rtap_data  out  `SRAM_WRAPPER_BUS_WIDTH  BIST output nibble.
- rtap_srams_bist_command  in  `BIST_OP_WIDTH  BIST command.
- rtap_srams_bist_data  in  `SRAM_WRAPPER_BUS_WIDTH  BIST input nibble.

## Operation
- Port priority: init > BIST > user. User requests are silently ignored while init_done=0 or bist_busy=1.
- **Init** (INIT_MEMORY_ON_RESET=1):
  - Index 0..2^ADDR_WIDTH−1, one full-mask zero write per cycle.
  - init_done rises the cycle after the last write and stays high until reset.
  - With INIT_MEMORY_ON_RESET=0, init_done=1 from reset.
- **Payload length:** NIB = ceil(DATA_WIDTH/4). Payloads travel MSB nibble first; data is zero-extended to 4·NIB bits.
- **BIST FSM states:** IDLE, ID, BSEL, ADDR, RW_CHECK, READ_SRAM, READ_WAIT, SEND_DATA, RECV_DATA, WRITE_SRAM.
  - **IDLE:** on SHIFT_ID, capture the nibble as ID high and go to ID.
  - **ID:** SHIFT_ID with {ID_hi, nibble}==SR_ID → BSEL; otherwise → IDLE.
  - **BSEL:** two SHIFT_BSEL nibbles (stored, unused) → ADDR.
  - **ADDR:** four SHIFT_ADDRESS nibbles build the 16-bit address → RW_CHECK. Bits above ADDR_WIDTH are ignored.
  - **RW_CHECK:** READ → READ_SRAM. SHIFT_DATA captures nibble 1 → RECV_DATA.
  - **READ_SRAM:** issue the read. **READ_WAIT:** load macro output into the shift register. Both advance unconditionally.
  - **SEND_DATA:** each SHIFT_DATA shifts left 4. After NIB shifts → IDLE.
  - **RECV_DATA:** each SHIFT_DATA appends a nibble at the LSB. When NIB nibbles are held → WRITE_SRAM.
  - **WRITE_SRAM:** one full-mask write to the BIST address → IDLE.
- Any unexpected command in ID through RECV_DATA aborts to IDLE with no memory access.
- bist_busy = 1 in states RW_CHECK through WRITE_SRAM.
- srams_rtap_data = top nibble of the send shift register; 0 outside SEND_DATA.
- **Read-during-write** (user ports, rd_addr==wr_addr, both enabled):
  - BYPASS_RDW=1: rd_data = (wr_data & wr_mask) | (macro_out & ~wr_mask).
  - BYPASS_RDW=0: unmasked bits old, masked bits undefined.

## Timing
- Reset (asynchronous, any state): FSM→IDLE, counters 0, shift registers 0, srams_rtap_data=0, bist_busy=0.
  - init_done=0 when INIT_MEMORY_ON_RESET=1, otherwise 1.
  - Bypass select register = 0.
  - rd_data is macro-driven and not reset.
- Assertion mid-init restarts init from index 0 after release. Assertion mid-BIST discards the transaction.
- User read: rd_en at cycle T → rd_data valid at T+1. User write is committed at the clk edge ending cycle T.
- BIST read: first valid output nibble appears 2 cycles after the READ command cycle.
- BIST write: committed at the edge ending WRITE_SRAM, one cycle after the last data nibble.
- Init occupies exactly 2^ADDR_WIDTH cycles.

## Structure
- Shared define header (existing): `BIST_OP_*, `BIST_OP_WIDTH, `SRAM_WRAPPER_BUS_WIDTH.
- Shared package: BIST state enum, function nib_count(width).
- Sub-module: tp_ram_bist_ctrl, the RTAP FSM with shift registers, parametrised by ADDR_WIDTH/DATA_WIDTH.
- Macro: tp_ram_asic or tp_ram_model, selected by generate.

## Test plan
- INIT=1, ADDR_WIDTH=4 → init_done rises after 16 cycles; reads of addresses 0..15 return 0; user writes during init are dropped.
- User write 0xDEADBEEF_01234567 to address 5, read address 5 next cycle → data returned at T+1.
- Same-cycle write 0xFFFF_FFFF_FFFF_FFFF with mask 0x0000_0000_FFFF_FFFF, read address 5 (old 0xDEADBEEF_01234567), BYPASS_RDW=1 → rd_data = 0xDEADBEEF_FFFFFFFF.
- BIST with SR_ID=0x3A, address 0x0007, 16-nibble write of 0x0123456789ABCDEF, then BIST read → srams_rtap_data emits 0,1,…,F over 16 shifts; bist_busy high throughout.
- SR_ID mismatch (0x3B sent), or a READ command while in BSEL → FSM returns to IDLE; memory unchanged; bist_busy stays 0.
- DATA_WIDTH=10 → NIB=3; BIST write of 0x2A5 reads back as nibbles 2, A, 5. Reset asserted mid-RECV_DATA → IDLE, no write.
